// File: rtl/proc_entry_ctrl.sv
// Front-panel entry sequencer for the 4-bit processor.
// Synchronizes and debounces the four entry buttons and the data switches,
// enforces the entry order opcode -> RR1/WR -> RR2/WD -> write-enable, and
// presents the captured fields with one-cycle load/exec/err strobes.
//
// Strobe semantics: ld_op/ld_rr1/ld_rr2/exec/err are registered one-cycle
// pulses; a field is valid on the same cycle its ld_* strobe is high, and
// there is no back-pressure (the datapath must accept every strobe).
module proc_entry_ctrl #(
  parameter int DEB_CYCLES = 16,
  parameter int DW         = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in,
  input  logic          op,
  input  logic          rr1_wr,
  input  logic          rr2_wd,
  input  logic          we,
  output logic [DW-1:0] opcode,
  output logic [DW-1:0] rr1,
  output logic [DW-1:0] rr2,
  output logic          ld_op,
  output logic          ld_rr1,
  output logic          ld_rr2,
  output logic          exec,
  output logic          err,
  output logic [2:0]    phase
);

  // Counter only needs to reach DEB_CYCLES-1.
  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  // Button bit order doubles as priority order: bit 0 wins.
  localparam int B_OP  = 0;
  localparam int B_RR1 = 1;
  localparam int B_RR2 = 2;
  localparam int B_WE  = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GOT_OP = 3'd1,
    S_GOT_R1 = 3'd2,
    S_GOT_R2 = 3'd3,
    S_EXEC   = 3'd4
  } state_t;

  state_t          state;
  logic [3:0]      btn_raw;
  logic [3:0]      btn_s1;
  logic [3:0]      btn_s2;
  logic [DW-1:0]   in_s1;
  logic [DW-1:0]   in_s2;
  logic [3:0]      deb;
  logic [3:0]      deb_q;
  logic [CW-1:0]   cnt [4];
  logic [3:0]      press;
  logic [3:0]      win;

  assign btn_raw = {we, rr2_wd, rr1_wr, op};

  // Two-flop synchronizers for the switches and the raw buttons.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_s1  <= '0;
      in_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      in_s1  <= in;
      in_s2  <= in_s1;
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
    end
  end

  // Debounce: a level must differ from the debounced value for DEB_CYCLES
  // consecutive cycles before it is accepted; any agreement restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (btn_s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          deb[i] <= btn_s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Delayed debounced levels for rising-edge (press) detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) deb_q <= '0;
    else     deb_q <= deb;
  end

  assign press = deb & ~deb_q;

  // Keep only the highest-priority press; losers are discarded silently.
  always_comb begin
    win = '0;
    if      (press[B_OP])  win[B_OP]  = 1'b1;
    else if (press[B_RR1]) win[B_RR1] = 1'b1;
    else if (press[B_RR2]) win[B_RR2] = 1'b1;
    else if (press[B_WE])  win[B_WE]  = 1'b1;
  end

  // Entry FSM with registered fields and strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      opcode <= '0;
      rr1    <= '0;
      rr2    <= '0;
      ld_op  <= 1'b0;
      ld_rr1 <= 1'b0;
      ld_rr2 <= 1'b0;
      exec   <= 1'b0;
      err    <= 1'b0;
    end else begin
      ld_op  <= 1'b0;
      ld_rr1 <= 1'b0;
      ld_rr2 <= 1'b0;
      exec   <= 1'b0;
      err    <= 1'b0;
      if (win[B_OP]) begin
        // Opcode entry restarts the sequence from any state.
        opcode <= in_s2;
        ld_op  <= 1'b1;
        state  <= S_GOT_OP;
      end else begin
        // EXEC lasts exactly one cycle regardless of other presses.
        if (state == S_EXEC) state <= S_IDLE;
        if (win[B_RR1]) begin
          if (state == S_GOT_OP) begin
            rr1    <= in_s2;
            ld_rr1 <= 1'b1;
            state  <= S_GOT_R1;
          end else begin
            err <= 1'b1;
          end
        end else if (win[B_RR2]) begin
          if (state == S_GOT_R1) begin
            rr2    <= in_s2;
            ld_rr2 <= 1'b1;
            state  <= S_GOT_R2;
          end else begin
            err <= 1'b1;
          end
        end else if (win[B_WE]) begin
          if (state == S_GOT_R2) begin
            exec  <= 1'b1;
            state <= S_EXEC;
          end else begin
            err <= 1'b1;
          end
        end
      end
    end
  end

  assign phase = state;

endmodule
